// File: rtl/clemensnasenberg_top.sv
// Two-source I2S mixer: averages sd1 and sd2 per channel, re-serialises the mix one
// frame later on sd_out and shows the upper magnitude bits of each mix on data_out.
module clemensnasenberg_top (
  input  logic [7:0] io_in,
  output logic [7:0] io_out
);

  logic sck, rst, ws, sd1, sd2;
  logic unused_in;

  assign sck       = io_in[0];
  assign rst       = io_in[1];
  assign ws        = io_in[2];
  assign sd1       = io_in[3];
  assign sd2       = io_in[4];
  assign unused_in = ^io_in[7:5];

  logic        ws_q, ws_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [15:0] sr1_q, sr1_d;
  logic [15:0] sr2_q, sr2_d;
  logic [15:0] mix_l_q, mix_l_d;
  logic [15:0] mix_r_q, mix_r_d;
  logic [15:0] tx_q, tx_d;
  logic [6:0]  level_q, level_d;
  logic        sd_out_q, sd_out_d;

  logic        boundary;
  logic [16:0] sum17;
  logic [15:0] mix;
  logic [15:0] mag;
  logic [15:0] tx_sel;

  assign boundary = ws ^ ws_q;
  // 17-bit sum cannot overflow; bits [16:1] are the arithmetic halving.
  assign sum17    = {sr1_q[15], sr1_q} + {sr2_q[15], sr2_q};
  assign mix      = sum17[16:1];
  assign tx_sel   = ws ? mix_r_q : mix_l_q;

  always_comb begin
    mag = mix[15] ? (16'd0 - mix) : mix;
    if (mix == 16'h8000) mag = 16'h7FFF;
  end

  always_comb begin
    ws_d     = ws;
    cnt_d    = cnt_q;
    sr1_d    = sr1_q;
    sr2_d    = sr2_q;
    mix_l_d  = mix_l_q;
    mix_r_d  = mix_r_q;
    tx_d     = tx_q;
    level_d  = level_q;
    sd_out_d = sd_out_q;
    if (boundary) begin
      // Bit on this edge is the old slot's tail and is dropped.
      cnt_d = 5'd0;
      sr1_d = 16'd0;
      sr2_d = 16'd0;
      if (ws_q) mix_r_d = mix;
      else      mix_l_d = mix;
      level_d  = mag[14:8];
      tx_d     = tx_sel;
      sd_out_d = tx_sel[15];
    end else begin
      if (cnt_q < 5'd16) begin
        sr1_d[4'd15 - cnt_q[3:0]] = sd1;
        sr2_d[4'd15 - cnt_q[3:0]] = sd2;
        cnt_d = cnt_q + 5'd1;
      end
      // Zero fill makes sd_out idle low once all 16 bits have gone out.
      tx_d     = {tx_q[14:0], 1'b0};
      sd_out_d = tx_q[14];
    end
  end

  always_ff @(posedge sck) begin
    if (rst) begin
      ws_q     <= 1'b0;
      cnt_q    <= 5'd0;
      sr1_q    <= 16'd0;
      sr2_q    <= 16'd0;
      mix_l_q  <= 16'd0;
      mix_r_q  <= 16'd0;
      tx_q     <= 16'd0;
      level_q  <= 7'd0;
      sd_out_q <= 1'b0;
    end else begin
      ws_q     <= ws_d;
      cnt_q    <= cnt_d;
      sr1_q    <= sr1_d;
      sr2_q    <= sr2_d;
      mix_l_q  <= mix_l_d;
      mix_r_q  <= mix_r_d;
      tx_q     <= tx_d;
      level_q  <= level_d;
      sd_out_q <= sd_out_d;
    end
  end

  assign io_out = {sd_out_q, level_q};

endmodule

// File: tb/tb_clemensnasenberg_top.sv
// Bench for the I2S mixer: fixed vector table, randomized slots against a
// slot-level reference model, and reset corner sequences.
module tb_clemensnasenberg_top;

  logic       sck = 1'b0;
  logic       rst = 1'b1;
  logic       ws = 1'b0;
  logic       sd1 = 1'b0;
  logic       sd2 = 1'b0;
  logic [2:0] unused_pins = 3'd0;
  logic [7:0] io_in;
  logic [7:0] io_out;

  assign io_in = {unused_pins, sd2, sd1, ws, rst, sck};

  clemensnasenberg_top dut (
    .io_in  (io_in),
    .io_out (io_out)
  );

  always #5 sck = ~sck;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: stored mix per channel, last level, last slot's words.
  logic [15:0] m_store[2];
  int          m_level;
  logic [15:0] m_pend1, m_pend2;
  int          m_pend_ch;

  typedef struct {
    logic [15:0] w1;
    logic [15:0] w2;
    int          len;
    logic [6:0]  exp_lvl;
    logic [15:0] exp_mix;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_edge(input logic r, input logic w, input logic a, input logic b);
    @(negedge sck);
    rst = r;
    ws = w;
    sd1 = a;
    sd2 = b;
    unused_pins = 3'($urandom_range(0, 7));
    @(posedge sck);
    #1;
  endtask

  task automatic model_reset();
    m_store[0] = 16'd0;
    m_store[1] = 16'd0;
    m_level = 0;
    m_pend1 = 16'd0;
    m_pend2 = 16'd0;
    m_pend_ch = 0;
  endtask

  // One slot of channel c lasting len edges; edge 0 is the ws change. Data bits
  // ride on edges 1..len-1, MSB first. Stops early after stop_at edges.
  task automatic send_slot(input int c, input logic [15:0] w1, input logic [15:0] w2,
                           input int len, input int stop_at, input bit pad_ones,
                           output logic [15:0] txw, output logic [6:0] lvl);
    int s, mix, a, nb;
    logic [15:0] t, keep;
    logic b1, b2, exp_sd;
    s = int'($signed(m_pend1)) + int'($signed(m_pend2));
    mix = s >>> 1;
    a = (mix < 0) ? -mix : mix;
    if (a > 32767) a = 32767;
    m_level = (a >> 8) & 127;
    m_store[m_pend_ch] = mix[15:0];
    t = m_store[c];
    txw = 16'd0;
    lvl = 7'd0;
    for (int k = 0; k < len && k < stop_at; k++) begin
      if (k == 0) begin
        b1 = 1'($urandom_range(0, 1));
        b2 = 1'($urandom_range(0, 1));
      end else if (k <= 16) begin
        b1 = w1[16-k];
        b2 = w2[16-k];
      end else begin
        b1 = pad_ones ? 1'b1 : 1'($urandom_range(0, 1));
        b2 = pad_ones ? 1'b1 : 1'($urandom_range(0, 1));
      end
      drive_edge(1'b0, c[0], b1, b2);
      exp_sd = (k < 16) ? t[15-k] : 1'b0;
      check("sd_out", int'(io_out[7]), int'(exp_sd));
      check("data_out", int'(io_out[6:0]), m_level);
      if (k < 16) txw[15-k] = io_out[7];
      if (k == 0) lvl = io_out[6:0];
    end
    nb = len - 1;
    keep = (nb >= 16) ? 16'hFFFF : ~(16'hFFFF >> nb);
    m_pend1 = w1 & keep;
    m_pend2 = w2 & keep;
    m_pend_ch = c;
  endtask

  logic [15:0] txw, dtx;
  logic [6:0]  lvl, dlvl;
  int          cur;
  logic [15:0] rw1, rw2;
  int          rlen;

  initial begin
    vecs[0] = '{16'h4000, 16'h2000, 17, 7'h30, 16'h3000};
    vecs[1] = '{16'h8000, 16'h8000, 17, 7'h7F, 16'h8000};
    vecs[2] = '{16'h7FFF, 16'h8001, 17, 7'h00, 16'h0000};
    vecs[3] = '{16'h1234, 16'h1234, 33, 7'h12, 16'h1234};
    vecs[4] = '{16'hA5FF, 16'hA5FF, 9,  7'h5B, 16'hA500};

    // Reset held for two edges with arbitrary inputs.
    for (int i = 0; i < 2; i++) begin
      drive_edge(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)));
      check("reset_io_out", int'(io_out), 0);
    end
    model_reset();

    // First slot after reset is right: mixes zero words, sends zero.
    send_slot(1, 16'd0, 16'd0, 17, 99, 1'b0, dtx, dlvl);
    check("post_reset_level", int'(dlvl), 0);
    cur = 0;

    foreach (vecs[i]) begin
      send_slot(cur, vecs[i].w1, vecs[i].w2, vecs[i].len, 99, 1'b1, dtx, dlvl);
      send_slot(1 - cur, 16'd0, 16'd0, 17, 99, 1'b0, dtx, lvl);
      check($sformatf("vec%0d_level", i), int'(lvl), int'(vecs[i].exp_lvl));
      send_slot(cur, 16'd0, 16'd0, vecs[i].len, 99, 1'b0, txw, dlvl);
      check($sformatf("vec%0d_tx", i), int'(txw), int'(vecs[i].exp_mix));
      cur = 1 - cur;
    end

    for (int i = 0; i < 40; i++) begin
      rw1 = 16'($urandom_range(0, 65535));
      rw2 = 16'($urandom_range(0, 65535));
      if ($urandom_range(0, 7) == 0) rw1 = 16'h8000;
      if ($urandom_range(0, 7) == 0) rw2 = 16'h8000;
      rlen = $urandom_range(5, 34);
      send_slot(cur, rw1, rw2, rlen, 99, 1'($urandom_range(0, 1)), dtx, dlvl);
      cur = 1 - cur;
    end

    // Reset after 8 data bits of a slot; partial word must leave no residue.
    send_slot(cur, 16'hFFFF, 16'hFFFF, 17, 9, 1'b0, dtx, dlvl);
    drive_edge(1'b1, cur[0], 1'b1, 1'b1);
    check("midslot_reset_io_out", int'(io_out), 0);
    model_reset();
    send_slot(1, 16'h4000, 16'h2000, 17, 99, 1'b0, dtx, dlvl);
    check("after_reset_level0", int'(dlvl), 0);
    check("after_reset_tx0", int'(dtx), 0);
    send_slot(0, 16'd0, 16'd0, 17, 99, 1'b0, dtx, lvl);
    check("after_reset_level", int'(lvl), 'h30);
    send_slot(1, 16'd0, 16'd0, 17, 99, 1'b0, txw, dlvl);
    check("after_reset_tx", int'(txw), 'h3000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/clemensnasenberg_top.md
CLEMENSNASENBERG_TOP -- requirements
Module: clemensnasenberg_top

Interface
REQ-001 io_in[0] sck  input  1  bit clock; the only clock; all state updates on its rising edge.
REQ-002 io_in[1] rst  input  1  reset; synchronous, active-high.
REQ-003 io_in[2] ws  input  1  I2S word select; 0 = left slot, 1 = right slot.
REQ-004 io_in[3] sd1  input  1  I2S serial data, source 1; 16-bit two's complement, MSB first.
REQ-005 io_in[4] sd2  input  1  I2S serial data, source 2; same format as sd1.
REQ-006 io_in[7:5]  input  3  unused; ignored.
REQ-007 io_out[6:0] data_out  output  7  level meter: magnitude of the most recent mixed sample.
REQ-008 io_out[7] sd_out  output  1  I2S serial data of the mixed stream; framed by the same ws.
REQ-009 All outputs SHALL be registered; no combinational path from io_in to io_out.

Function
REQ-010 Each rising sck edge SHALL sample ws, sd1, sd2; ws_q holds ws from the previous edge.
REQ-011 Boundary edge: ws != ws_q; the slot just ended is channel ws_q; the new slot is channel ws.
REQ-012 On a boundary edge: bit counter cnt (5 bits) SHALL clear to 0 and receive shift registers sr1/sr2 (16 bits) SHALL clear to 0 after their contents are consumed.
REQ-013 One-bit I2S delay: the bit sampled at the boundary edge belongs to the old slot and is discarded; MSB of the new word is sampled on the next edge.
REQ-014 Non-boundary edge with cnt < 16: sd1/sd2 written to bit (15 - cnt) of sr1/sr2, cnt increments; at cnt = 16 further bits ignored (slots longer than 16 bits allowed).
REQ-015 Slots shorter than 16 bits: missing LSBs SHALL be 0 (e.g. 8-bit slot carrying 0xA5 -> word 0xA500).
REQ-016 On a boundary edge: mix = (sext17(sr1) + sext17(sr2)) >>> 1, arithmetic, truncated to 16 bits; never overflows.
REQ-017 mix SHALL be stored in the channel register of channel ws_q (mix_l or mix_r).
REQ-018 On the same boundary edge data_out SHALL load bits [14:8] of |mix|; |-32768| saturates to 32767.
REQ-019 On a boundary edge the transmit register SHALL load the stored mix register of the new channel ws (value written one frame earlier), and sd_out SHALL be set to its bit 15 on that same edge.
REQ-020 On the k-th non-boundary edge after the boundary (k = 1..15), sd_out SHALL carry bit 15-k; for k >= 16 sd_out SHALL be 0.
REQ-021 Consequence: a downstream I2S receiver sampling on rising sck, one bit after ws change, reads the mixed word MSB first; latency = one frame (sample received in frame f transmitted in the same channel slot of frame f+1).
REQ-022 A boundary edge in the middle of a transmission SHALL abort it and start the new word.
REQ-023 data_out SHALL hold its value between boundary edges.

Reset
REQ-024 rst = 1 at a rising sck edge SHALL clear ws_q, cnt, sr1, sr2, mix_l, mix_r, transmit register, data_out and sd_out to 0; rst has priority over all other actions.
REQ-025 After rst deasserts, the first boundary SHALL be detected normally against ws_q = 0 (a first slot with ws = 1 mixes/latches zero words).
REQ-026 Reset asserted mid-frame SHALL discard any partial word; outputs read 0 until the next boundary loads new values.

Verification
REQ-027 rst = 1 for 2 edges, any inputs -> io_out = 0x00 on the next edge and held while rst = 1.
REQ-028 Left slot sd1 = 0x4000, sd2 = 0x2000, 16-bit slots -> at the next boundary data_out = 0x30; in the following frame's left slot sd_out serialises 0x3000 MSB first starting at the boundary edge.
REQ-029 Right slot sd1 = 0x8000, sd2 = 0x8000 -> mix = 0x8000, data_out = 0x7F; next right slot sd_out serialises 0x8000.
REQ-030 sd1 = 0x7FFF, sd2 = 0x8001 -> mix = 0x0000, data_out = 0x00, sd_out stays 0 for that slot.
REQ-031 32-bit slots with sd1 = sd2 = 0x1234 in the first 16 bits and 1s in the trailing 16 -> mix = 0x1234, data_out = 0x12; sd_out = 0 after bit 0.
REQ-032 rst pulsed for one edge mid-slot after 8 bits received -> outputs 0; the next full frame mixes correctly with no residue from the aborted word.
